// File: rtl/pipeline_scheduler.sv
// Round-robin launcher for a single shared render pipeline: grants one requester,
// starts the pipeline with its config, waits out the busy window and reports done/timeout.
module pipeline_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned CFG_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*CFG_W-1:0]   i_req_cfg,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NUM_REQ-1:0]         o_done,
  output logic [NUM_REQ-1:0]         o_timeout,
  output logic                       o_start_pipeline,
  output logic [CFG_W-1:0]           o_pipeline_cfg,
  input  logic                       i_pipeline_busy,
  output logic                       o_active,
  output logic [$clog2(NUM_REQ)-1:0] o_owner
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE,
    S_FAULT,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] timeout_q, timeout_d;
  logic               start_q, start_d;
  logic               active_q, active_d;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic [CFG_W-1:0]   winner_cfg;
  int unsigned        scan;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first pending request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    scan   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = i + 32'(rr_ptr_q);
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      cand = IDX_W'(scan);
      if (!found && i_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    winner_cfg = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (winner == IDX_W'(r)) winner_cfg = i_req_cfg[r*CFG_W +: CFG_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    owner_d  = owner_q;
    cfg_d    = cfg_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_enable && found) begin
          owner_d  = winner;
          cfg_d    = winner_cfg;
          rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (wd_q != WD_LIMIT) wd_d = wd_q + 1'b1;
        if (i_pipeline_busy)        state_d = S_RUN;
        else if (wd_q == WD_LIMIT)  state_d = S_FAULT;
      end
      // Busy falling is checked first so completion wins over an expiring watchdog.
      S_RUN: begin
        if (wd_q != WD_LIMIT) wd_d = wd_q + 1'b1;
        if (!i_pipeline_busy)       state_d = S_DONE;
        else if (wd_q == WD_LIMIT)  state_d = S_FAULT;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!i_pipeline_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pulse outputs are decoded from the next state so they register alongside it.
    start_d   = (state_d == S_LAUNCH);
    grant_d   = (state_d == S_LAUNCH) ? onehot(owner_d) : '0;
    done_d    = (state_d == S_DONE)   ? onehot(owner_d) : '0;
    timeout_d = (state_d == S_FAULT)  ? onehot(owner_d) : '0;
    active_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      wd_q      <= '0;
      owner_q   <= '0;
      cfg_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      timeout_q <= '0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      owner_q   <= owner_d;
      cfg_q     <= cfg_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      active_q  <= active_d;
    end
  end

  assign o_grant          = grant_q;
  assign o_done           = done_q;
  assign o_timeout        = timeout_q;
  assign o_start_pipeline = start_q;
  assign o_pipeline_cfg   = cfg_q;
  assign o_active         = active_q;
  assign o_owner          = owner_q;

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Directed bench: dut_l (long watchdog) covers arbitration and enable/reset,
// dut_s (TIMEOUT_CYCLES=8) covers watchdog behaviour. Both share the input stimulus.
module tb_pipeline_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_enable;
  logic [3:0]   i_req;
  logic [127:0] i_req_cfg;
  logic         i_pipeline_busy;

  logic [3:0]  grant_l, done_l, timeout_l;
  logic        start_l, active_l;
  logic [31:0] cfg_l;
  logic [1:0]  owner_l;

  logic [3:0]  grant_s, done_s, timeout_s;
  logic        start_s, active_s;
  logic [31:0] cfg_s;
  logic [1:0]  owner_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_scheduler #(.NUM_REQ(4), .CFG_W(32), .TIMEOUT_CYCLES(1024)) dut_l (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_req(i_req), .i_req_cfg(i_req_cfg),
    .o_grant(grant_l), .o_done(done_l), .o_timeout(timeout_l), .o_start_pipeline(start_l),
    .o_pipeline_cfg(cfg_l), .i_pipeline_busy(i_pipeline_busy), .o_active(active_l),
    .o_owner(owner_l)
  );

  pipeline_scheduler #(.NUM_REQ(4), .CFG_W(32), .TIMEOUT_CYCLES(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_req(i_req), .i_req_cfg(i_req_cfg),
    .o_grant(grant_s), .o_done(done_s), .o_timeout(timeout_s), .o_start_pipeline(start_s),
    .o_pipeline_cfg(cfg_s), .i_pipeline_busy(i_pipeline_busy), .o_active(active_s),
    .o_owner(owner_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    i_req = '0;
    i_pipeline_busy = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    rst_n = 1'b0;
    tick;
    total++;
    if ({grant_l, done_l, timeout_l, start_l, active_l, owner_l} !== 17'd0 || cfg_l !== 32'd0)
      begin bad++; $display("FAIL reset_l got=%b/%h exp=0", {grant_l, done_l, timeout_l, start_l, active_l, owner_l}, cfg_l); end
    total++;
    if ({grant_s, done_s, timeout_s, start_s, active_s, owner_s} !== 17'd0 || cfg_s !== 32'd0)
      begin bad++; $display("FAIL reset_s got=%b/%h exp=0", {grant_s, done_s, timeout_s, start_s, active_s, owner_s}, cfg_s); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int n_extra;
    i_req = 4'b0100;
    tick;
    total++; if (grant_l !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=0100", grant_l); end
    total++; if (start_l !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", start_l); end
    total++; if (cfg_l !== 32'hA5) begin bad++; $display("FAIL single_cfg got=%h exp=a5", cfg_l); end
    total++; if (owner_l !== 2'd2) begin bad++; $display("FAIL single_owner got=%0d exp=2", owner_l); end
    i_req = '0;
    tick;
    tick;
    total++; if (start_l !== 1'b0 || grant_l !== 4'b0) begin bad++; $display("FAIL single_pulse_len got=%b/%b exp=0/0000", start_l, grant_l); end
    i_pipeline_busy = 1'b1;
    n_extra = 0;
    repeat (10) begin tick; if (done_l !== 4'b0) n_extra++; end
    i_pipeline_busy = 1'b0;
    tick;
    total++; if (done_l !== 4'b0100) begin bad++; $display("FAIL single_done got=%b exp=0100", done_l); end
    repeat (3) begin tick; if (done_l !== 4'b0) n_extra++; end
    total++; if (n_extra !== 0) begin bad++; $display("FAIL single_done_once got=%0d extra exp=0", n_extra); end
    total++; if (active_l !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", active_l); end
    // rr_ptr should now be 3: requester 3 beats requester 0
    i_req = 4'b1001;
    tick;
    total++; if (grant_l !== 4'b1000) begin bad++; $display("FAIL single_rrptr got=%b exp=1000", grant_l); end
    total++; if (cfg_l !== 32'hD3) begin bad++; $display("FAIL single_cfg3 got=%h exp=d3", cfg_l); end
    i_req = '0;
    i_pipeline_busy = 1'b1;
    tick;
    tick;
    i_pipeline_busy = 1'b0;
    tick;
    total++; if (done_l !== 4'b1000) begin bad++; $display("FAIL single_done3 got=%b exp=1000", done_l); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [3:0]  exp_g;
    logic [3:0]  got_g;
    logic [31:0] exp_cfg [4];
    int          waited;
    exp_cfg[0] = 32'hB0; exp_cfg[1] = 32'hC1; exp_cfg[2] = 32'hA5; exp_cfg[3] = 32'hD3;
    do_reset;
    i_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_g  = 4'b0001 << (k % 4);
      waited = -1;
      for (int c = 0; c < 10; c++) begin
        tick;
        if (grant_l !== 4'b0) begin waited = c; break; end
      end
      got_g = grant_l;
      total++; if (got_g !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, got_g, exp_g); end
      total++; if (cfg_l !== exp_cfg[k % 4]) begin bad++; $display("FAIL rr_cfg%0d got=%h exp=%h", k, cfg_l, exp_cfg[k % 4]); end
      total++; if (waited !== (k == 0 ? 0 : 1)) begin bad++; $display("FAIL rr_gap%0d got=%0d exp=%0d", k, waited, (k == 0 ? 0 : 1)); end
      i_req = i_req & ~exp_g;
      i_pipeline_busy = 1'b1;
      tick;
      tick;
      i_pipeline_busy = 1'b0;
      tick;
      total++; if (done_l !== exp_g) begin bad++; $display("FAIL rr_done%0d got=%b exp=%b", k, done_l, exp_g); end
      i_req = i_req | exp_g;
    end
    i_req = '0;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    int n, n_done;
    do_reset;
    i_req = 4'b0001;
    tick;
    total++; if (grant_s !== 4'b0001) begin bad++; $display("FAIL to_grant got=%b exp=0001", grant_s); end
    i_req = '0;
    n = 0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (done_s !== 4'b0) n_done++;
      if (timeout_s !== 4'b0) begin n = c + 1; break; end
    end
    total++; if (n !== 9) begin bad++; $display("FAIL to_latency got=%0d exp=9", n); end
    total++; if (timeout_s !== 4'b0001) begin bad++; $display("FAIL to_pulse got=%b exp=0001", timeout_s); end
    tick;
    total++; if (timeout_s !== 4'b0 || done_s !== 4'b0) begin bad++; $display("FAIL to_one_pulse got=%b/%b exp=0000/0000", timeout_s, done_s); end
    tick;
    total++; if (active_s !== 1'b0) begin bad++; $display("FAIL to_drain_exit got=%b exp=0", active_s); end
    total++; if (n_done !== 0) begin bad++; $display("FAIL to_no_done got=%0d exp=0", n_done); end
    i_req = 4'b0010;
    tick;
    total++; if (grant_s !== 4'b0010) begin bad++; $display("FAIL to_next_grant got=%b exp=0010", grant_s); end
    i_req = '0;
    i_pipeline_busy = 1'b1;
    tick;
    tick;
    i_pipeline_busy = 1'b0;
    tick;
    total++; if (done_s !== 4'b0010) begin bad++; $display("FAIL to_next_done got=%b exp=0010", done_s); end
    tick;
  endtask

  task automatic test_stuck_busy;
    int n_to, at_to, n_gr, n_dn, waited;
    i_req = 4'b0100;
    tick;
    total++; if (grant_s !== 4'b0100) begin bad++; $display("FAIL stuck_grant got=%b exp=0100", grant_s); end
    i_req = 4'b0001;
    i_pipeline_busy = 1'b1;
    n_to = 0; at_to = 0; n_gr = 0; n_dn = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (timeout_s !== 4'b0) begin n_to++; at_to = c; end
      if (grant_s !== 4'b0) n_gr++;
      if (done_s !== 4'b0) n_dn++;
    end
    total++; if (n_to !== 1 || at_to !== 9) begin bad++; $display("FAIL stuck_timeout got=%0d@%0d exp=1@9", n_to, at_to); end
    total++; if (n_gr !== 0) begin bad++; $display("FAIL stuck_no_grant got=%0d exp=0", n_gr); end
    total++; if (n_dn !== 0) begin bad++; $display("FAIL stuck_no_done got=%0d exp=0", n_dn); end
    i_pipeline_busy = 1'b0;
    waited = 0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (done_s !== 4'b0) n_dn++;
      if (grant_s !== 4'b0) begin waited = c; break; end
    end
    total++; if (waited !== 2 || grant_s !== 4'b0001) begin bad++; $display("FAIL stuck_release got=%b@%0d exp=0001@2", grant_s, waited); end
    total++; if (n_dn !== 0) begin bad++; $display("FAIL stuck_late_done got=%0d exp=0", n_dn); end
    i_req = '0;
    i_pipeline_busy = 1'b1;
    tick;
    tick;
    i_pipeline_busy = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_race;
    int n_to;
    i_req = 4'b1000;
    tick;
    total++; if (grant_s !== 4'b1000) begin bad++; $display("FAIL race_grant got=%b exp=1000", grant_s); end
    i_req = '0;
    i_pipeline_busy = 1'b1;
    repeat (8) tick;
    i_pipeline_busy = 1'b0;
    tick;
    total++; if (done_s !== 4'b1000) begin bad++; $display("FAIL race_done got=%b exp=1000", done_s); end
    n_to = (timeout_s !== 4'b0) ? 1 : 0;
    repeat (4) begin tick; if (timeout_s !== 4'b0) n_to++; end
    total++; if (n_to !== 0) begin bad++; $display("FAIL race_no_timeout got=%0d exp=0", n_to); end
  endtask

  task automatic test_enable_reset;
    int n_gr, n_ev;
    do_reset;
    i_enable = 1'b0;
    i_req = 4'b0010;
    n_gr = 0;
    repeat (5) begin tick; if (grant_l !== 4'b0 || start_l !== 1'b0) n_gr++; end
    total++; if (n_gr !== 0) begin bad++; $display("FAIL en_blocked got=%0d exp=0", n_gr); end
    i_enable = 1'b1;
    tick;
    total++; if (grant_l !== 4'b0010) begin bad++; $display("FAIL en_grant got=%b exp=0010", grant_l); end
    i_req = '0;
    i_pipeline_busy = 1'b1;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    total++;
    if ({grant_l, done_l, timeout_l, start_l, active_l, owner_l} !== 17'd0 || cfg_l !== 32'd0)
      begin bad++; $display("FAIL en_reset got=%b/%h exp=0", {grant_l, done_l, timeout_l, start_l, active_l, owner_l}, cfg_l); end
    rst_n = 1'b1;
    i_pipeline_busy = 1'b0;
    n_ev = 0;
    repeat (3) begin tick; if (done_l !== 4'b0 || timeout_l !== 4'b0 || active_l !== 1'b0) n_ev++; end
    total++; if (n_ev !== 0) begin bad++; $display("FAIL en_quiet got=%0d exp=0", n_ev); end
    i_req = 4'hF;
    tick;
    total++; if (grant_l !== 4'b0001) begin bad++; $display("FAIL en_rrptr got=%b exp=0001", grant_l); end
    i_req = '0;
    tick;
    tick;
  endtask

  initial begin
    rst_n = 1'b0;
    i_enable = 1'b1;
    i_req = '0;
    i_req_cfg = {32'hD3, 32'hA5, 32'hC1, 32'hB0};
    i_pipeline_busy = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_stuck_busy;
    test_race;
    test_enable_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
